// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the asynchronous-SRAM burst controller: default
// parameter values, the controller state encoding and the width of the beat /
// turnaround down-counter.
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WAIT_CYCLES = 2;   // legal 0..15
  localparam int DEF_LEN_W       = 4;
  localparam int DEF_TURN_CYCLES = 1;   // legal 1..7

  // Wide enough for WAIT_CYCLES (max 15) and TURN_CYCLES-1 (max 6).
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_WR_REC  = 3'd4,
    ST_TURN    = 3'd5
  } state_e;

endpackage

// File: rtl/sram_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_beat_timer
// Loadable down-counter that paces SRAM beats and bus turnaround. Loading N
// makes done_o go high N cycles later (immediately for N = 0), so a phase
// that loads N lasts N+1 cycles when it ends on done_o.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   load_i        load load_val_i this edge (wins over counting)
//   load_val_i    value to load
//   done_o        counter has reached zero
// ---------------------------------------------------------------------------
module sram_beat_timer
  import sram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/sram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// sram_burst_ctrl
// Burst controller for an asynchronous SRAM. Accepts one read or write burst
// command at a time, paces each beat for WAIT_CYCLES+1 cycles and leaves the
// bus idle for TURN_CYCLES cycles after every burst.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_re, cmd_addr, cmd_len  1 = read; start address; beats minus one
//   wr_data/wr_valid/wr_ready  write beat handshake (ready only in WR_WAIT)
//   rd_data/rd_valid           read beat data with one-cycle strobe
//   busy                       controller not in IDLE
//   sram_address               SRAM address pins
//   sram_data_write/_read      SRAM data out / in
//   sram_data_oe               drive SRAM data pins
//   n_ce1, ce2, n_we, n_oe     SRAM strobes decoded from ce/we/oe registers
// ---------------------------------------------------------------------------
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_re,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_write,
  input  logic [DATA_W-1:0] sram_data_read,
  output logic              sram_data_oe,
  output logic              n_ce1,
  output logic              ce2,
  output logic              n_we,
  output logic              n_oe
);

  localparam logic [CNT_W-1:0] BEAT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  state_e              state_q, state_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic                oe_q, oe_d;
  logic                data_oe_q, data_oe_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [LEN_W-1:0]    beats_q, beats_d;     // beats remaining after the current one

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_done;

  sram_beat_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ce_d       = ce_q;
    we_d       = we_q;
    oe_d       = oe_q;
    data_oe_d  = data_oe_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    beats_d    = beats_q;
    rd_valid_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is low in the first cycle after reset even though the
        // state is IDLE, so it gates acceptance rather than the state alone.
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          beats_d = cmd_len;
          ce_d    = 1'b1;
          we_d    = 1'b0;
          if (cmd_re) begin
            state_d   = ST_READ;
            oe_d      = 1'b1;
            data_oe_d = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = BEAT_LOAD;
          end else begin
            state_d   = ST_WR_WAIT;
            oe_d      = 1'b0;
            data_oe_d = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (tmr_done) begin
          rdata_d    = sram_data_read;
          rd_valid_d = 1'b1;
          tmr_load   = 1'b1;
          if (beats_q != '0) begin
            // Next beat follows directly with ce/oe still asserted.
            beats_d = beats_q - LEN_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            tmr_val = BEAT_LOAD;
          end else begin
            ce_d    = 1'b0;
            oe_d    = 1'b0;
            state_d = ST_TURN;
            tmr_val = TURN_LOAD;
          end
        end
      end

      ST_WR_WAIT: begin
        if (wr_valid && wr_ready_q) begin
          wdata_d  = wr_data;
          we_d     = 1'b1;
          state_d  = ST_WRITE;
          tmr_load = 1'b1;
          tmr_val  = BEAT_LOAD;
        end
      end

      ST_WRITE: begin
        if (tmr_done) begin
          we_d    = 1'b0;
          state_d = ST_WR_REC;
        end
      end

      // Single recovery cycle: address and data stay put after we falls.
      ST_WR_REC: begin
        if (beats_q != '0) begin
          beats_d = beats_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_WR_WAIT;
        end else begin
          ce_d      = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ST_TURN;
          tmr_load  = 1'b1;
          tmr_val   = TURN_LOAD;
        end
      end

      ST_TURN: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake and status outputs are registered copies of the next state.
    cmd_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WR_WAIT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      data_oe_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      data_oe_q   <= data_oe_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      beats_q     <= beats_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign wr_ready        = wr_ready_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rdata_q;
  assign busy            = busy_q;
  assign sram_address    = addr_q;
  assign sram_data_write = wdata_q;
  assign sram_data_oe    = data_oe_q;

  // Strobe pins decode straight from the ce/we/oe registers.
  assign n_ce1 = ~ce_q;
  assign ce2   = ce_q;
  assign n_we  = ~we_q;
  assign n_oe  = ~oe_q;

endmodule
